// File: rtl/cpu_axi_pkg.sv
// Shared AXI4 field encodings and the data-memory responder state encoding.
package cpu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        RSP_IDLE,
        RSP_AR,
        RSP_R,
        RSP_AW_W,
        RSP_B,
        RSP_DONE,
        RSP_DRAIN
    } rsp_state_e;

endpackage

// File: rtl/dmem_axi_responder.sv
// Turns each held MEM-stage data request into one single-beat AXI4 read or write,
// holding the completion until MEM consumes it or withdraws the request.
module dmem_axi_responder
    import cpu_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // MEM-stage request side
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  mem_fire,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  write_finish,
    output logic                  bus_err,
    // AXI read address
    output logic [3:0]            arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    // AXI read data
    input  logic [3:0]            rid,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI write address
    output logic [3:0]            awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    // AXI write data
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI write response
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    rsp_state_e state_reg;
    logic       aw_done_reg;
    logic       w_done_reg;
    logic       abandoned_reg;

    logic       aw_hs;
    logic       w_hs;
    logic       aw_all;
    logic       w_all;
    logic       drop_now;

    // Single-beat transactions: only one outstanding ID and always the last beat.
    logic       unused_axi_fields;
    assign unused_axi_fields = ^{rid, rlast, bid};

    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arsize  = AXI_SIZE_WORD;
    assign awsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign wlast   = 1'b1;

    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign aw_all   = aw_done_reg | aw_hs;
    assign w_all    = w_done_reg | w_hs;
    assign drop_now = abandoned_reg | ~en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RSP_IDLE;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            abandoned_reg <= 1'b0;
            rdata         <= '0;
            rdata_valid   <= 1'b0;
            write_finish  <= 1'b0;
            bus_err       <= 1'b0;
            araddr        <= '0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            awaddr        <= '0;
            awvalid       <= 1'b0;
            wdata_o       <= '0;
            wstrb         <= '0;
            wvalid        <= 1'b0;
            bready        <= 1'b0;
        end else begin
            case (state_reg)
                RSP_IDLE: begin
                    abandoned_reg <= 1'b0;
                    if (en) begin
                        if (we) begin
                            awaddr      <= addr;
                            wdata_o     <= wdata;
                            wstrb       <= wmask;
                            awvalid     <= 1'b1;
                            wvalid      <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            state_reg   <= RSP_AW_W;
                        end else begin
                            araddr    <= addr;
                            arvalid   <= 1'b1;
                            state_reg <= RSP_AR;
                        end
                    end
                end
                // Once issued, a transaction always runs to completion; a withdrawn
                // request only suppresses the completion pulse.
                RSP_AR: begin
                    if (!en)
                        abandoned_reg <= 1'b1;
                    if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        state_reg <= RSP_R;
                    end
                end
                RSP_R: begin
                    if (rvalid) begin
                        rready        <= 1'b0;
                        abandoned_reg <= 1'b0;
                        if (drop_now) begin
                            state_reg <= RSP_IDLE;
                        end else begin
                            rdata       <= rdata_i;
                            bus_err     <= (rresp != AXI_RESP_OKAY);
                            rdata_valid <= 1'b1;
                            state_reg   <= RSP_DONE;
                        end
                    end else if (!en) begin
                        abandoned_reg <= 1'b1;
                    end
                end
                RSP_AW_W: begin
                    if (!en)
                        abandoned_reg <= 1'b1;
                    if (aw_hs)
                        awvalid <= 1'b0;
                    if (w_hs)
                        wvalid <= 1'b0;
                    aw_done_reg <= aw_all;
                    w_done_reg  <= w_all;
                    if (aw_all && w_all) begin
                        bready    <= 1'b1;
                        state_reg <= RSP_B;
                    end
                end
                RSP_B: begin
                    if (bvalid) begin
                        bready        <= 1'b0;
                        abandoned_reg <= 1'b0;
                        if (drop_now) begin
                            state_reg <= RSP_IDLE;
                        end else begin
                            bus_err      <= (bresp != AXI_RESP_OKAY);
                            write_finish <= 1'b1;
                            state_reg    <= RSP_DONE;
                        end
                    end else if (!en) begin
                        abandoned_reg <= 1'b1;
                    end
                end
                RSP_DONE: begin
                    if (mem_fire || !en) begin
                        rdata_valid  <= 1'b0;
                        write_finish <= 1'b0;
                        bus_err      <= 1'b0;
                        state_reg    <= RSP_IDLE;
                    end
                end
                default: begin
                    state_reg <= RSP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axi_responder.sv
// Directed bench for dmem_axi_responder: the bench plays the AXI slave by hand
// and checks every step against hand-computed values.
module tb_dmem_axi_responder;
    import cpu_axi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, we, mem_fire;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        rdata_valid, write_finish, bus_err;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata_i, wdata_o;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int tests = 0;
    int fails = 0;
    int ar_count = 0;
    int aw_count = 0;
    int w_count  = 0;

    always #5 clk = ~clk;

    dmem_axi_responder dut (
        .clk(clk), .reset(reset),
        .en(en), .we(we), .addr(addr), .wmask(wmask), .wdata(wdata), .mem_fire(mem_fire),
        .rdata(rdata), .rdata_valid(rdata_valid), .write_finish(write_finish), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_i(rdata_i), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata_o(wdata_o), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always @(posedge clk) begin
        if (arvalid && arready) ar_count <= ar_count + 1;
        if (awvalid && awready) aw_count <= aw_count + 1;
        if (wvalid && wready)   w_count  <= w_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; we = 1'b0; mem_fire = 1'b0;
        addr = '0; wdata = '0; wmask = '0;
        arready = 1'b0; rid = 4'd1; rdata_i = '0; rresp = AXI_RESP_OKAY; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = AXI_RESP_OKAY; bvalid = 1'b0;
        tick(); tick();
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("rst_finish", {rdata_valid, write_finish, bus_err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_state", dut.state_reg, RSP_IDLE);
        check("const_fields", {arlen, awlen, arsize, awsize, arburst, awburst, wlast},
              {7'd0, 8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1});
        reset = 1'b0;
        tick();

        // 1: load with immediate slave, minimum latency and hold until mem_fire
        arready = 1'b1; rvalid = 1'b1; rdata_i = 32'hdeadbeef;
        en = 1'b1; we = 1'b0; addr = 32'h1c000100;
        tick();
        check("t1_arvalid", arvalid, 32'd1);
        check("t1_araddr", araddr, 32'h1c000100);
        check("t1_arid", arid, 32'd1);
        tick();
        check("t1_rready", {arvalid, rready, rdata_valid}, 32'b010);
        tick();
        check("t1_rvalid_c3", rdata_valid, 32'd1);
        check("t1_rdata", rdata, 32'hdeadbeef);
        rdata_i = 32'h0;
        tick(); tick();
        check("t1_hold", {rdata_valid, write_finish, bus_err}, 32'b100);
        check("t1_hold_data", rdata, 32'hdeadbeef);
        mem_fire = 1'b1;
        tick();
        check("t1_clear", rdata_valid, 32'd0);
        check("t1_idle", dut.state_reg, RSP_IDLE);
        mem_fire = 1'b0; en = 1'b0; arready = 1'b0; rvalid = 1'b0;
        tick();

        // 2: store, wready two cycles after awready
        aw_count = 0; w_count = 0;
        en = 1'b1; we = 1'b1; addr = 32'h1c000204; wmask = 4'b0011; wdata = 32'h12345678;
        tick();
        check("t2_valids", {awvalid, wvalid}, 32'b11);
        check("t2_awaddr", awaddr, 32'h1c000204);
        check("t2_wstrb", wstrb, 32'b0011);
        check("t2_wdata", wdata_o, 32'h12345678);
        addr = 32'h0; wmask = 4'b1111;
        awready = 1'b1;
        tick();
        check("t2_aw_drop", {awvalid, wvalid, bready}, 32'b010);
        awready = 1'b0;
        tick();
        wready = 1'b1;
        tick();
        check("t2_to_b", {awvalid, wvalid, bready}, 32'b001);
        wready = 1'b0; bvalid = 1'b1; bresp = AXI_RESP_OKAY;
        tick();
        bvalid = 1'b0;
        check("t2_finish", {write_finish, rdata_valid, bus_err}, 32'b100);
        check("t2_hs_counts", {aw_count[15:0], w_count[15:0]}, {16'd1, 16'd1});
        mem_fire = 1'b1;
        tick();
        check("t2_clear", write_finish, 32'd0);
        mem_fire = 1'b0; en = 1'b0;
        tick();

        // 3: load withdrawn in R; the beat still completes with no rdata_valid
        arready = 1'b1;
        en = 1'b1; we = 1'b0; addr = 32'h1c000300;
        tick();
        tick();
        check("t3_in_r", rready, 32'd1);
        en = 1'b0;
        tick(); tick(); tick();
        check("t3_rready_held", {rready, rdata_valid}, 32'b10);
        rvalid = 1'b1; rdata_i = 32'hcafef00d;
        tick();
        check("t3_abandon", {rready, rdata_valid, write_finish}, 32'b000);
        check("t3_idle", dut.state_reg, RSP_IDLE);
        rvalid = 1'b0;
        en = 1'b1; addr = 32'h1c000400;
        tick();
        check("t3_next_ar", {arvalid, araddr}, {1'b1, 32'h1c000400});
        tick();
        rvalid = 1'b1; rdata_i = 32'h0badf00d;
        tick();
        check("t3_next_data", {rdata_valid, rdata}, {1'b1, 32'h0badf00d});
        rvalid = 1'b0; mem_fire = 1'b1;
        tick();
        mem_fire = 1'b0; en = 1'b0; arready = 1'b0;
        tick();

        // 4: store answered with SLVERR; same-cycle AW and W handshakes
        awready = 1'b1; wready = 1'b1;
        en = 1'b1; we = 1'b1; addr = 32'h1c000600; wmask = 4'b1111; wdata = 32'ha5a5a5a5;
        tick();
        tick();
        check("t4_both_hs", {awvalid, wvalid, bready}, 32'b001);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = AXI_RESP_SLVERR;
        tick();
        check("t4_err", {write_finish, bus_err, rdata_valid}, 32'b110);
        bvalid = 1'b0; bresp = AXI_RESP_OKAY; mem_fire = 1'b1;
        tick();
        check("t4_clear", {write_finish, bus_err}, 32'b00);
        mem_fire = 1'b0; en = 1'b0;
        tick();

        // 5: back-to-back loads to the same address with en held
        ar_count = 0;
        arready = 1'b1; rvalid = 1'b1; rdata_i = 32'h11111111;
        en = 1'b1; we = 1'b0; addr = 32'h1c000500;
        tick(); tick(); tick();
        check("t5_first", {rdata_valid, rdata}, {1'b1, 32'h11111111});
        mem_fire = 1'b1; rdata_i = 32'h22222222;
        tick();
        check("t5_gap", rdata_valid, 32'd0);
        mem_fire = 1'b0;
        tick();
        check("t5_second_ar", arvalid, 32'd1);
        tick(); tick();
        check("t5_second", {rdata_valid, rdata}, {1'b1, 32'h22222222});
        check("t5_ar_count", ar_count, 32'd2);
        mem_fire = 1'b1;
        tick();
        mem_fire = 1'b0; en = 1'b0; arready = 1'b0; rvalid = 1'b0;
        tick();

        // 6: reset while in AW_W
        en = 1'b1; we = 1'b1; addr = 32'h1c000700; wdata = 32'h77777777;
        tick();
        check("t6_in_aw_w", {awvalid, wvalid}, 32'b11);
        reset = 1'b1;
        tick();
        check("t6_valids", {arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("t6_outs", {rdata_valid, write_finish, bus_err}, 32'd0);
        check("t6_data", {rdata | awaddr | wdata_o}, 32'd0);
        check("t6_state", dut.state_reg, RSP_IDLE);
        reset = 1'b0; en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
